// File: rtl/boot_loader.sv
// Boot-port initiator: assembles host bytes into 32-bit words (MSB first) and
// writes them to consecutive icache addresses while holding the core in boot.
module boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  prog_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              boot_up,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [31:0]       boot_datai,
    output logic              boot_web,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              boot_up_q, boot_up_d;
    logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
    logic [31:0]       boot_datai_q, boot_datai_d;
    logic              boot_web_q, boot_web_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              accept;
    logic              len_ok;

    assign accept = in_valid && in_ready_q && !abort;
    assign len_ok = (prog_len != '0) && ({1'b0, prog_len} <= MAX_LEN);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        last_d       = last_q;
        in_ready_d   = in_ready_q;
        boot_up_d    = boot_up_q;
        boot_addr_d  = boot_addr_q;
        boot_datai_d = boot_datai_q;
        boot_web_d   = 1'b1;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        checksum_d   = checksum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        // Store the index of the final word so the full-range
                        // length (2^ADDR_W) still fits in ADDR_W bits.
                        last_d      = ADDR_W'(prog_len - LEN_W'(1));
                        checksum_d  = '0;
                        boot_addr_d = '0;
                        byte_cnt_d  = '0;
                        boot_up_d   = 1'b1;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    boot_up_d  = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (accept) begin
                    word_d     = {word_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        boot_datai_d = {word_q[23:0], in_data};
                        in_ready_d   = 1'b0;
                        boot_web_d   = 1'b0;
                        state_d      = WRITE;
                    end
                end
            end
            WRITE: begin
                // The write strobe is already low this cycle, so an abort here
                // still lets the word land before returning to IDLE.
                checksum_d = checksum_q + boot_datai_q;
                if (abort) begin
                    boot_up_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (boot_addr_q == last_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    boot_addr_d = boot_addr_q + ADDR_W'(1);
                    byte_cnt_d  = '0;
                    in_ready_d  = 1'b1;
                    state_d     = RECV;
                end
            end
            DONE: begin
                boot_up_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            last_q       <= '0;
            in_ready_q   <= 1'b0;
            boot_up_q    <= 1'b0;
            boot_addr_q  <= '0;
            boot_datai_q <= '0;
            boot_web_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            boot_up_q    <= boot_up_d;
            boot_addr_q  <= boot_addr_d;
            boot_datai_q <= boot_datai_d;
            boot_web_q   <= boot_web_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            checksum_q   <= checksum_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign boot_up    = boot_up_q;
    assign boot_addr  = boot_addr_q;
    assign boot_datai = boot_datai_q;
    assign boot_web   = boot_web_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign checksum   = checksum_q;

endmodule
